enemy_sprite_engine: RTL

ENEMY_SPRITE_ENGINE -- requirements
Module: enemy_sprite_engine

---
 rtl/enemy_pkg.sv | 14 +
 rtl/enemy_slot.sv | 139 +++++++++++++
 rtl/enemy_sprite_engine.sv | 95 +++++++++
 3 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy sprite engine: slot lifecycle states
// and the width of world-space x coordinates.
package enemy_pkg;

  // World x coordinates (scroll offset + screen column) are 13 bits wide.
  localparam int WORLD_W = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    SQUISH = 2'd2
  } slot_state_t;

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: lifecycle FSM, walk/squish counters, frame-start shadow
// copies of the position, and the registered stage-1 hit test and local
// sprite ROM address for the current pixel.
module enemy_slot
  import enemy_pkg::*;
#(
  parameter int SPRITE_W      = 16,
  parameter int SPRITE_H      = 16,
  parameter int NUM_FRAMES    = 4,
  parameter int ANIM_PERIOD   = 8,
  parameter int SQUISH_FRAMES = 30,
  parameter int H_ACTIVE      = 576,
  parameter int V_ACTIVE      = 240,
  parameter int ADDR_W        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic [11:0]        offset,
  input  logic [WORLD_W-1:0] x,
  input  logic [9:0]         y,
  input  logic               spawn,
  input  logic               kill,
  output logic               alive,
  output logic               hit,
  output logic [ADDR_W-1:0]  addr
);

  localparam int AW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int SW = (SQUISH_FRAMES > 1) ? $clog2(SQUISH_FRAMES + 1) : 1;
  // Compare width: one bit wider than world coordinates so x+SPRITE_W never wraps.
  localparam int CW = WORLD_W + 1;

  slot_state_t        state_q, state_d;
  logic [AW-1:0]      tick_q;
  logic [FW-1:0]      walk_frame_q;
  logic [SW-1:0]      sq_cnt_q;
  logic               armed_q;
  logic [WORLD_W-1:0] sx_q;
  logic [9:0]         sy_q;

  logic               spawn_ok, kill_ok;
  logic [WORLD_W-1:0] wx;
  logic               in_x, in_y, in_win, hit_c;
  logic [FW-1:0]      frame_c;
  logic [ADDR_W-1:0]  addr_c;

  assign spawn_ok = (state_q == IDLE) && spawn;
  assign kill_ok  = (state_q == WALK) && kill;

  // State register.
  // NOTE: asynchronous active-low reset in the sensitivity list; every
  // sequential block uses non-blocking assignments so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: spawn only counts from IDLE, kill only from WALK.
  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (spawn) state_d = WALK;
      WALK:    if (kill)  state_d = SQUISH;
      SQUISH:  if (frame_start && sq_cnt_q == SW'(SQUISH_FRAMES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Animation/squish counters, display arming and position shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      walk_frame_q <= '0;
      sq_cnt_q     <= '0;
      armed_q      <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
    end else begin
      if (spawn_ok) begin
        tick_q       <= '0;
        walk_frame_q <= '0;
      end else if (state_q == WALK && !kill && frame_start) begin
        if (tick_q == AW'(ANIM_PERIOD - 1)) begin
          tick_q       <= '0;
          walk_frame_q <= (walk_frame_q == FW'(NUM_FRAMES - 2)) ? '0 : walk_frame_q + 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end

      if (kill_ok)                                sq_cnt_q <= '0;
      else if (state_q == SQUISH && frame_start)  sq_cnt_q <= sq_cnt_q + 1'b1;

      // A freshly spawned enemy stays hidden until its shadows are loaded
      // at the next frame start.
      if (spawn_ok)         armed_q <= 1'b0;
      else if (frame_start) armed_q <= 1'b1;

      if (frame_start) begin
        sx_q <= x;
        sy_q <= y;
      end
    end
  end

  // Hit test and local address against the shadow position.
  always_comb begin
    wx      = WORLD_W'(hcount) + WORLD_W'(offset);
    in_x    = (CW'(wx) >= CW'(sx_q)) && (CW'(wx) < CW'(sx_q) + CW'(SPRITE_W));
    in_y    = (CW'(vcount) >= CW'(sy_q)) && (CW'(vcount) < CW'(sy_q) + CW'(SPRITE_H));
    in_win  = (CW'(hcount) < CW'(H_ACTIVE)) && (CW'(vcount) < CW'(V_ACTIVE));
    hit_c   = (state_q != IDLE) && armed_q && in_x && in_y && in_win;
    frame_c = (state_q == SQUISH) ? FW'(NUM_FRAMES - 1) : walk_frame_q;
    addr_c  = ADDR_W'(wx - sx_q)
            + ADDR_W'(vcount - sy_q) * ADDR_W'(SPRITE_W)
            + ADDR_W'(frame_c) * ADDR_W'(SPRITE_W * SPRITE_H);
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit  <= 1'b0;
      addr <= '0;
    end else begin
      hit  <= hit_c;
      addr <= hit_c ? addr_c : '0;
    end
  end

  assign alive = (state_q != IDLE);

endmodule

// File: rtl/enemy_sprite_engine.sv
// Enemy sprite engine: NUM_ENEMIES slots each produce a registered hit and
// local ROM address; a second stage picks the lowest-index hit.
module enemy_sprite_engine
  import enemy_pkg::*;
#(
  parameter int NUM_ENEMIES   = 4,
  parameter int SPRITE_W      = 16,
  parameter int SPRITE_H      = 16,
  parameter int NUM_FRAMES    = 4,
  parameter int ANIM_PERIOD   = 8,
  parameter int SQUISH_FRAMES = 30,
  parameter int H_ACTIVE      = 576,
  parameter int V_ACTIVE      = 240,
  localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H * NUM_FRAMES),
  localparam int IDX_W  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
  input  logic                           pixel_clk_in,
  input  logic                           rst_n_in,
  input  logic [10:0]                    hcount_in,
  input  logic [9:0]                     vcount_in,
  input  logic [11:0]                    offset_background,
  input  logic [NUM_ENEMIES*WORLD_W-1:0] x_in,
  input  logic [NUM_ENEMIES*10-1:0]      y_in,
  input  logic [NUM_ENEMIES-1:0]         spawn_in,
  input  logic [NUM_ENEMIES-1:0]         kill_in,
  output logic [ADDR_W-1:0]              image_addr,
  output logic                           in_sprite,
  output logic [IDX_W-1:0]               enemy_idx,
  output logic [NUM_ENEMIES-1:0]         alive_out
);

  logic              frame_start;
  logic              hit_s  [NUM_ENEMIES];
  logic [ADDR_W-1:0] addr_s [NUM_ENEMIES];
  logic              win_hit;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
    enemy_slot #(
      .SPRITE_W      (SPRITE_W),
      .SPRITE_H      (SPRITE_H),
      .NUM_FRAMES    (NUM_FRAMES),
      .ANIM_PERIOD   (ANIM_PERIOD),
      .SQUISH_FRAMES (SQUISH_FRAMES),
      .H_ACTIVE      (H_ACTIVE),
      .V_ACTIVE      (V_ACTIVE),
      .ADDR_W        (ADDR_W)
    ) u_slot (
      .clk         (pixel_clk_in),
      .rst_n       (rst_n_in),
      .frame_start (frame_start),
      .hcount      (hcount_in),
      .vcount      (vcount_in),
      .offset      (offset_background),
      .x           (x_in[i*WORLD_W +: WORLD_W]),
      .y           (y_in[i*10 +: 10]),
      .spawn       (spawn_in[i]),
      .kill        (kill_in[i]),
      .alive       (alive_out[i]),
      .hit         (hit_s[i]),
      .addr        (addr_s[i])
    );
  end

  // Priority select: scanning downward lets the lowest hitting index win.
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        win_hit  = 1'b1;
        win_idx  = IDX_W'(i);
        win_addr = addr_s[i];
      end
    end
  end

  // Stage-2 output register.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      in_sprite  <= 1'b0;
      enemy_idx  <= '0;
      image_addr <= '0;
    end else begin
      in_sprite  <= win_hit;
      enemy_idx  <= win_idx;
      image_addr <= win_addr;
    end
  end

endmodule
